// File: rtl/shift_seq_pkg.sv
// Shared encodings for the multi-cycle shift sequencer.
// The optional rotate op is enabled by defining SHIFT_SEQ_ROTATE_EN.
package shift_seq_pkg;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   localparam int STEP_MAX = 3;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational 0..3-bit shifter for SLL/SRL/SRA and, when SHIFT_SEQ_ROTATE_EN
// is defined, ROL; without the macro op 11 passes the operand through.
module shift_step
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic [1:0]       step_i,
   output logic [WIDTH-1:0] data_o
);

`ifdef SHIFT_SEQ_ROTATE_EN
   logic [2*WIDTH-1:0] rot_s;
`endif

   // Single-step shift selected by op
   always_comb begin
      data_o = data_i;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_s  = {data_i, data_i} << step_i;
`endif
      case (op_i)
         OP_SLL:  data_o = data_i << step_i;
         OP_SRL:  data_o = data_i >> step_i;
         OP_SRA:  data_o = WIDTH'($signed(data_i) >>> step_i);
`ifdef SHIFT_SEQ_ROTATE_EN
         OP_ROL:  data_o = rot_s[2*WIDTH-1:WIDTH];
`else
         OP_ROL:  data_o = data_i;
`endif
         default: data_o = data_i;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: chains up to 3-bit steps until the amount is spent.
// Rotate (op 11) is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   state_t           state_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] data_q;
   logic [AMT_W-1:0] rem_q;
   logic             out_valid_q;

   logic [1:0]       step_s;
   logic [AMT_W-1:0] rem_d;
   logic [WIDTH-1:0] data_d;
   logic [AMT_W-1:0] amt_d;

   // Step size, remaining amount after this step, and the accepted amount
   always_comb begin
      step_s = 2'b00;
      rem_d  = rem_q;
      amt_d  = in_amt;
      if (rem_q > AMT_W'(STEP_MAX)) begin
         step_s = 2'(STEP_MAX);
      end else begin
         step_s = rem_q[1:0];
      end
      rem_d = rem_q - AMT_W'(step_s);
`ifdef SHIFT_SEQ_ROTATE_EN
      amt_d = in_amt;
`else
      // Pass-through op takes the amt=0 timing regardless of in_amt
      if (in_op == OP_ROL) begin
         amt_d = {AMT_W{1'b0}};
      end else begin
         amt_d = in_amt;
      end
`endif
   end

   shift_step #(.WIDTH(WIDTH)) u_step (
      .op_i   (op_q),
      .data_i (data_q),
      .step_i (step_s),
      .data_o (data_d)
   );

   // Control FSM with working register, remaining counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= OP_SLL;
         data_q      <= {WIDTH{1'b0}};
         rem_q       <= {AMT_W{1'b0}};
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  op_q    <= in_op;
                  data_q  <= in_data;
                  rem_q   <= amt_d;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               data_q <= data_d;
               rem_q  <= rem_d;
               if (rem_d == {AMT_W{1'b0}}) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases then random commands
// checked against a whole-amount reference shift.
module tb_shift_sequencer;

   localparam int WIDTH = 8;
   localparam int AMT_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [WIDTH-1:0] in_data;
   logic [AMT_W-1:0] in_amt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Whole-amount reference result
   function automatic logic [7:0] ref_shift(input logic [1:0] op, input logic [7:0] d, input int amt);
      logic [7:0] r;
      r = d;
      case (op)
         2'd0: r = d << amt;
         2'd1: r = d >> amt;
         2'd2: for (int i = 0; i < amt; i++) r = {r[7], r[7:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
         2'd3: for (int i = 0; i < 8; i++) r[(i + amt) % 8] = d[i];
`else
         2'd3: r = d;
`endif
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic int ref_busy(input logic [1:0] op, input int amt);
      int a;
      a = amt;
`ifndef SHIFT_SEQ_ROTATE_EN
      if (op == 2'd3) a = 0;
`endif
      if (a == 0) return 1;
      return (a + 2) / 3;
   endfunction

   task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input logic [2:0] amt,
                          input logic [7:0] exp_data, input int exp_n, input int hold);
      int cnt;
      logic [7:0] held;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_data = d; in_amt = amt;
      check("in_ready_idle", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0; in_data = 8'($urandom); in_amt = 3'($urandom); in_op = 2'($urandom);
      cnt = 0;
      while (!out_valid && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      check("busy_cycles", cnt, exp_n);
      check("out_data", {24'd0, out_data}, {24'd0, exp_data});
      check("in_ready_done", {31'd0, in_ready}, 32'd0);
      held = out_data;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; in_data = ~held; in_amt = 3'd1; in_op = 2'd0;
         @(negedge clk);
         in_valid = 1'b0;
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_data", {24'd0, out_data}, {24'd0, held});
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("release_valid", {31'd0, out_valid}, 32'd0);
      check("release_in_ready", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [1:0] op;
      logic [7:0] d;
      logic [2:0] amt;
      rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_data = 8'd0; in_amt = 3'd0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);

      run_cmd(2'd0, 8'h0B, 3'd5, 8'h60, 2, 0);
      run_cmd(2'd2, 8'h90, 3'd7, 8'hFF, 3, 0);
      run_cmd(2'd1, 8'h90, 3'd7, 8'h01, 3, 0);
      run_cmd(2'd1, 8'h90, 3'd0, 8'h90, 1, 0);
      run_cmd(2'd0, 8'h03, 3'd2, 8'h0C, 1, 4);

      // Reset in the middle of a command discards it
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'd0; in_data = 8'hFF; in_amt = 3'd7;
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_out_data", {24'd0, out_data}, 32'd0);
      @(negedge clk);
      check("midrst_no_result", {31'd0, out_valid}, 32'd0);
      run_cmd(2'd0, 8'h01, 3'd3, 8'h08, 1, 0);

`ifdef SHIFT_SEQ_ROTATE_EN
      run_cmd(2'd3, 8'h81, 3'd1, 8'h03, 1, 0);
`else
      run_cmd(2'd3, 8'h81, 3'd1, 8'h81, 1, 0);
      run_cmd(2'd3, 8'h81, 3'd7, 8'h81, 1, 0);
`endif

      for (int k = 0; k < 40; k++) begin
         op  = 2'($urandom_range(0, 3));
         d   = 8'($urandom);
         amt = 3'($urandom_range(0, 7));
         run_cmd(op, d, amt, ref_shift(op, d, int'(amt)), ref_busy(op, int'(amt)),
                 int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller that performs a WIDTH-bit shift of arbitrary amount by repeatedly driving a narrow 0–3-bit step shifter. It accepts one command at a time over a valid/ready handshake and returns the result over a second valid/ready handshake. It sits between the ALU issue logic and the shift datapath. It replaces a full barrel shifter where area matters more than latency.

## Interface
- WIDTH, 8: operand/result width; must be ≥4.
- AMT_W, $clog2(WIDTH): shift-amount width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid && in_ready.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (see Configuration).
- in_data  in  WIDTH  operand.
- in_amt  in  AMT_W  shift amount, 0..WIDTH-1.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  WIDTH  shifted result.

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> BUSY on accept. Latch op, data into the working register and amt into the remaining counter rem.
- BUSY, each cycle:
  - step = min(rem, 3).
  - Working register <= step_shift(op, reg, step); rem <= rem - step.
  - Go to DONE when rem - step == 0.
  - amt=0 still spends exactly one BUSY cycle (step 0).
- DONE -> IDLE when out_ready=1. out_data holds the working register and is stable for the whole DONE period.
- Step semantics:
  - SLL zero-fills from the LSB.
  - SRL zero-fills from the MSB.
  - SRA replicates the current MSB.
  - ROL moves MSBs into the LSBs.
- A chained result equals the single shift by the full amount (e.g. SRA of a negative value saturates to all-ones).
- in_valid is ignored outside IDLE. Inputs are not sampled unless the command is accepted.
- No command is dropped or duplicated. Exactly one out_valid period follows each accept.

## Timing
- Reset values: state IDLE, in_ready=1 in the first cycle after reset, out_valid=0, out_data=0, rem=0.
- BUSY cycles: n = max(1, ceil(amt/3)).
- Latency: with accept at edge k, out_valid=1 in the cycle after edge k+n.
- Throughput: one command per n+2 cycles with out_ready held high.
- Back-to-back: out_ready=1 in DONE returns to IDLE. A new command can be accepted one cycle later; there is no same-cycle DONE->accept bypass.
- out_data and out_valid are registered. in_ready is decoded from state only, with no combinational path from any input.
- rst asserted in any state forces the reset values at the next edge. An in-flight command is discarded with no partial result.

## Configuration
- SHIFT_SEQ_ROTATE_EN defined: op 11 is ROL, rotate left by amt.
- SHIFT_SEQ_ROTATE_EN undefined:
  - op 11 is a pass-through; out_data = in_data.
  - Timing is identical to amt=0 (one BUSY cycle), regardless of in_amt.
  - The rotate mux is absent from step_shift.

## Structure
- Package shift_seq_pkg holds:
  - op encodings: OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROL=2'b11.
  - STEP_MAX=3.
  - state enum: IDLE, BUSY, DONE.
- Sub-module shift_step: combinational WIDTH-parameterised shift by 0..3 for the four ops. The ROL arm is guarded by SHIFT_SEQ_ROTATE_EN.
- Top level holds the FSM, the working register and the rem counter.

## Test plan
- SLL, in_data=0x0B, amt=5, WIDTH=8, accept at edge 0 -> 2 BUSY cycles, out_valid after edge 2, out_data=0x60.
- SRA, in_data=0x90, amt=7 -> 3 BUSY cycles, out_data=0xFF. SRL of the same operand and amount -> 0x01.
- SRL, in_data=0x90, amt=0 -> 1 BUSY cycle, out_data=0x90.
- Backpressure: out_ready=0 for 4 cycles in DONE:
  - out_data and out_valid stay stable, in_ready=0.
  - A competing in_valid pulse is ignored.
  - Release -> IDLE next cycle.
- rst pulsed mid-BUSY (SLL 0xFF, amt=7):
  - Next cycle: state IDLE, out_valid=0, out_data=0.
  - A following SLL 0x01, amt=3 -> 0x08.
- op=11, in_data=0x81, amt=1:
  - With SHIFT_SEQ_ROTATE_EN -> 0x03.
  - Without -> 0x81 after 1 BUSY cycle.
